// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 LED controller.
// Holds SPI command codes, channel count and the transmitter state encoding.
// No ports; imported by the controller top.
package ws2812_pkg;

  localparam logic [7:0] CMD_WR_DATA = 8'hDA;
  localparam logic [7:0] CMD_REFRESH = 8'h2C;
  localparam int         N_CH        = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_LATCH = 2'd2
  } tx_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_if.sv
// SPI-side pin bundle of the controller: sclk, mosi, cs_n (active low), dc.
// master: whoever drives the pins (host / bench); slave: the SPI receiver.
// Pure wiring, no state.
interface ws2812_if;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic dc;

  modport master (output sclk, mosi, cs_n, dc);
  modport slave  (input  sclk, mosi, cs_n, dc);
endinterface

// File: rtl/ws2812_spi_slave.sv
// Purpose: mode-0 SPI byte receiver, oversampled in clk_in through 2-flop synchronizers.
// Latency: byte_valid pulses one cycle after the synchronized 8th SCLK rising edge.
// Backpressure: none; byte_valid is a single-cycle pulse that must be consumed.
// Ports: clk_in/rst_in (sync, active high), spi (slave modport),
//        byte_valid/byte_data/byte_is_data (completed byte and its latched dc).
module ws2812_spi_slave (
  input  logic           clk_in,
  input  logic           rst_in,
  ws2812_if.slave        spi,
  output logic           byte_valid,
  output logic [7:0]     byte_data,
  output logic           byte_is_data
);

  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] cs_n_sync;
  logic [1:0] dc_sync;
  logic       sclk_prev;
  logic [6:0] shift;
  logic [2:0] bit_cnt;
  logic       sclk_rise;

  // Edge detect on the synchronized copy so MOSI (same sync depth) is aligned.
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_sync    <= '0;
      mosi_sync    <= '0;
      cs_n_sync    <= 2'b11;
      dc_sync      <= '0;
      sclk_prev    <= 1'b0;
      shift        <= '0;
      bit_cnt      <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      byte_is_data <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], spi.sclk};
      mosi_sync  <= {mosi_sync[0], spi.mosi};
      cs_n_sync  <= {cs_n_sync[0], spi.cs_n};
      dc_sync    <= {dc_sync[0], spi.dc};
      sclk_prev  <= sclk_sync[1];
      byte_valid <= 1'b0;
      if (cs_n_sync[1]) begin
        // Deselect throws away any partial byte.
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid   <= 1'b1;
          byte_data    <= {shift, mosi_sync[1]};
          byte_is_data <= dc_sync[1];
        end
      end
    end
  end

endmodule

// File: rtl/ws2812_led_controller.sv
// Purpose: SPI-loaded 8-channel WS2812 driver; 0xDA rewinds the write pointer, 0x2C sends a frame.
// Latency: first output rising edge 2 clk_in cycles after the REFRESH byte completes.
// Backpressure: none; REFRESH while busy is dropped, data past channel 7 is dropped.
// Ports: clk_in, rst_in (sync, active high); dc_in, spi_sclk_in, spi_mosi_in, spi_cs_n_in (SPI host);
//        ws2812_data_out[7:0] (one serial line per channel, GRB order, MSB first).
module ws2812_led_controller
  import ws2812_pkg::*;
#(
  parameter int N_LED = 64,
  parameter int T0H   = 80,
  parameter int T1H   = 160,
  parameter int T_BIT = 250,
  parameter int T_RST = 10000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       dc_in,
  input  logic       spi_sclk_in,
  input  logic       spi_mosi_in,
  input  logic       spi_cs_n_in,
  output logic [7:0] ws2812_data_out
);

  localparam int N_BYTE = 3 * N_LED;
  localparam int IDX_W  = (N_BYTE > 1) ? $clog2(N_BYTE) : 1;
  localparam int CNT_W  = $clog2(max2(T_BIT, T_RST) + 1);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_BYTE - 1);
  localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] T_BIT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] T_RST_LAST = CNT_W'(T_RST - 1);

  // ---------------- SPI receive ----------------
  ws2812_if spi_bus ();
  assign spi_bus.sclk = spi_sclk_in;
  assign spi_bus.mosi = spi_mosi_in;
  assign spi_bus.cs_n = spi_cs_n_in;
  assign spi_bus.dc   = dc_in;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;

  ws2812_spi_slave u_spi (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .spi          (spi_bus.slave),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data)
  );

  // ---------------- Write pointer ----------------
  logic [2:0]       wr_ch;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_done;   // set after channel 7 wraps; data dropped until 0xDA
  logic             wr_en;
  logic             refresh_req;

  assign wr_en       = byte_valid & byte_is_data & ~wr_done;
  assign refresh_req = byte_valid & ~byte_is_data & (byte_data == CMD_REFRESH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ch   <= '0;
      wr_idx  <= '0;
      wr_done <= 1'b0;
    end else if (byte_valid && !byte_is_data && byte_data == CMD_WR_DATA) begin
      wr_ch   <= '0;
      wr_idx  <= '0;
      wr_done <= 1'b0;
    end else if (wr_en) begin
      if (wr_idx == IDX_LAST) begin
        wr_idx <= '0;
        if (wr_ch == 3'd7) wr_done <= 1'b1;
        else               wr_ch   <= wr_ch + 3'd1;
      end else begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
    end
  end

  // ---------------- Channel buffers ----------------
  // Asynchronous read so the current byte of every channel is visible in the
  // cycle it is needed; writes may land mid-frame (tearing is acceptable).
  logic [IDX_W-1:0] tx_idx;
  logic [7:0]       rd_byte [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_buf
    logic [7:0] mem [N_BYTE];
    always_ff @(posedge clk_in) begin
      if (wr_en && wr_ch == 3'(g)) mem[wr_idx] <= byte_data;
    end
    assign rd_byte[g] = mem[tx_idx];
  end

  // ---------------- Transmitter FSM ----------------
  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [IDX_W-1:0] tx_idx_nxt;
  logic [7:0]       out_nxt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= TX_IDLE;
      cnt             <= '0;
      bit_idx         <= 3'd7;
      tx_idx          <= '0;
      ws2812_data_out <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bit_idx         <= bit_idx_nxt;
      tx_idx          <= tx_idx_nxt;
      ws2812_data_out <= out_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    tx_idx_nxt  = tx_idx;
    out_nxt     = '0;
    case (state)
      TX_IDLE: begin
        if (refresh_req) begin
          state_nxt   = TX_SEND;
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd7;
          tx_idx_nxt  = '0;
        end
      end
      TX_SEND: begin
        // cnt is the position inside the bit period; high while below the bit's high time.
        for (int c = 0; c < N_CH; c++) begin
          out_nxt[c] = (cnt < (rd_byte[c][bit_idx] ? T1H_C : T0H_C));
        end
        if (cnt == T_BIT_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = bit_idx - 3'd1;   // wraps 0 -> 7 for the next byte
          if (bit_idx == 3'd0) begin
            if (tx_idx == IDX_LAST) state_nxt  = TX_LATCH;
            else                    tx_idx_nxt = tx_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      TX_LATCH: begin
        if (cnt == T_RST_LAST) begin
          state_nxt = TX_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_led_controller.sv
// Bench for ws2812_led_controller with shortened timing parameters.
// A buffer model is updated as bytes are sent; each accepted REFRESH queues the
// expected frame, which is popped and compared against the decoded output waveform.
module tb_ws2812_led_controller;
  import ws2812_pkg::*;

  localparam int NL     = 2;
  localparam int P_T0H  = 4;
  localparam int P_T1H  = 8;
  localparam int P_TBIT = 12;
  localparam int P_TRST = 100;
  localparam int NB     = 3 * NL;
  localparam int FW     = 8 * NB * 8;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] ws2812_data_out;

  ws2812_if spi ();

  ws2812_led_controller #(
    .N_LED (NL),
    .T0H   (P_T0H),
    .T1H   (P_T1H),
    .T_BIT (P_TBIT),
    .T_RST (P_TRST)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .dc_in           (spi.dc),
    .spi_sclk_in     (spi.sclk),
    .spi_mosi_in     (spi.mosi),
    .spi_cs_n_in     (spi.cs_n),
    .ws2812_data_out (ws2812_data_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_rise_cyc = 0;

  // Buffer model and scoreboard
  logic [7:0]    mdl [8][NB];
  int            mdl_ch = 0;
  int            mdl_idx = 0;
  bit            mdl_full = 1'b0;
  logic [FW-1:0] exp_q [$];

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f = '0;
    for (int ch = 0; ch < 8; ch++)
      for (int i = 0; i < NB; i++)
        f[(ch*NB + i)*8 +: 8] = mdl[ch][i];
    return f;
  endfunction

  task automatic spi_bit(input logic v);
    spi.mosi = v;
    spi.sclk = 1'b0;
    repeat (3) @(negedge clk_in);
    spi.sclk = 1'b1;
    last_rise_cyc = cyc;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data);
    @(negedge clk_in);
    spi.cs_n = 1'b1;
    spi.dc   = is_data;          // dc moves only while deselected
    repeat (2) @(negedge clk_in);
    spi.cs_n = 1'b0;
    repeat (2) @(negedge clk_in);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    send_byte(c, 1'b0);
    if (c == CMD_WR_DATA) begin
      mdl_ch = 0; mdl_idx = 0; mdl_full = 1'b0;
    end
  endtask

  task automatic send_data(input logic [7:0] v);
    send_byte(v, 1'b1);
    if (!mdl_full) begin
      mdl[mdl_ch][mdl_idx] = v;
      if (mdl_idx == NB - 1) begin
        mdl_idx = 0;
        if (mdl_ch == 7) mdl_full = 1'b1;
        else             mdl_ch++;
      end else begin
        mdl_idx++;
      end
    end
  endtask

  task automatic send_refresh(input bit accept);
    if (accept) exp_q.push_back(model_frame());
    send_byte(CMD_REFRESH, 1'b0);
  endtask

  task automatic fill_buffers(input logic [7:0] base, input logic [7:0] step);
    send_cmd(CMD_WR_DATA);
    for (int i = 0; i < 8*NB; i++) send_data(base + 8'(i) * step);
  endtask

  task automatic quiet_check(input string name, input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (ws2812_data_out !== 8'h00) act++;
    end
    n_checks++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL %s: %0d active output samples, required 0", name, act);
    end
  endtask

  // Decode one frame from the output lines and compare with the queued expectation.
  task automatic capture_frame(input string name, input int extra);
    logic [FW-1:0] exp_f;
    logic [FW-1:0] got_f = '0;
    int lat = -1;
    int bad_width = 0;
    int bad_shape = 0;
    int act = 0;
    int hc [8];
    bit low_seen [8];
    exp_f = '0;
    if (exp_q.size() > 0) exp_f = exp_q.pop_front();
    for (int w = 0; w < 50 && lat < 0; w++) begin
      @(negedge clk_in);
      if (ws2812_data_out !== 8'h00) lat = cyc - last_rise_cyc;
    end
    n_checks++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL %s_start: no rising edge within 50 cycles, required one", name);
      return;
    end
    // two synchronizer flops + edge detect, then at most 4 cycles from byte completion
    n_checks++;
    if (lat > 7) begin
      n_fail++;
      $display("FAIL %s_latency: %0d cycles after last SCLK rise, required <= 7", name, lat);
    end
    for (int b = 0; b < NB*8; b++) begin
      for (int ch = 0; ch < 8; ch++) begin hc[ch] = 0; low_seen[ch] = 1'b0; end
      for (int c = 0; c < P_TBIT; c++) begin
        for (int ch = 0; ch < 8; ch++) begin
          if (ws2812_data_out[ch]) begin
            if (low_seen[ch]) bad_shape++;
            hc[ch]++;
          end else begin
            low_seen[ch] = 1'b1;
          end
        end
        @(negedge clk_in);
      end
      for (int ch = 0; ch < 8; ch++) begin
        if (hc[ch] == P_T1H) got_f[(ch*NB + b/8)*8 + (7 - b%8)] = 1'b1;
        else if (hc[ch] != P_T0H) bad_width++;
      end
    end
    n_checks++;
    if (bad_width !== 0) begin
      n_fail++;
      $display("FAIL %s_bit_width: %0d bits with high time not %0d/%0d, required 0", name, bad_width, P_T0H, P_T1H);
    end
    n_checks++;
    if (bad_shape !== 0) begin
      n_fail++;
      $display("FAIL %s_bit_shape: %0d high samples after low within a bit period, required 0", name, bad_shape);
    end
    for (int ch = 0; ch < 8; ch++) begin
      n_checks++;
      if (got_f[ch*NB*8 +: NB*8] !== exp_f[ch*NB*8 +: NB*8]) begin
        n_fail++;
        $display("FAIL %s_ch%0d: got %h required %h", name, ch,
                 got_f[ch*NB*8 +: NB*8], exp_f[ch*NB*8 +: NB*8]);
      end
    end
    for (int i = 0; i < P_TRST; i++) begin
      if (ws2812_data_out !== 8'h00) act++;
      @(negedge clk_in);
    end
    n_checks++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL %s_latch_low: %0d active samples in latch window, required 0", name, act);
    end
    if (extra > 0) quiet_check({name, "_no_second_frame"}, extra);
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    repeat (4) @(negedge clk_in);
    n_checks++;
    if (ws2812_data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: got %h required 00", ws2812_data_out);
    end
    rst_in = 1'b0;
    mdl_ch = 0; mdl_idx = 0; mdl_full = 1'b0;
    quiet_check("idle_after_reset", 50);
  endtask

  task automatic test_basic();
    fill_buffers(8'h00, 8'h00);
    send_cmd(CMD_WR_DATA);
    send_data(8'hFF);
    send_data(8'h00);
    send_data(8'h81);
    send_refresh(1'b1);
    capture_frame("basic", 0);
  endtask

  task automatic test_wrap_channel();
    send_cmd(CMD_WR_DATA);
    for (int i = 0; i < NB + 1; i++) send_data(8'h10 + 8'(i));
    send_refresh(1'b1);
    capture_frame("wrap_ch1", 0);
  endtask

  task automatic test_drop_after_full();
    send_cmd(CMD_WR_DATA);
    for (int i = 0; i < 8*NB; i++) send_data(8'(i) * 8'd3 + 8'd1);
    send_data(8'hEE);
    send_data(8'hEE);
    send_refresh(1'b1);
    capture_frame("drop_full", 0);
  endtask

  task automatic test_back_to_back();
    send_refresh(1'b1);
    fork
      capture_frame("busy_refresh", 200);
      begin
        repeat (100) @(negedge clk_in);
        send_refresh(1'b0);          // lands during SEND
        repeat (420) @(negedge clk_in);
        send_refresh(1'b0);          // lands during LATCH
      end
    join
  endtask

  task automatic test_partial_cs();
    @(negedge clk_in);
    spi.dc = 1'b0;
    spi.cs_n = 1'b0;
    repeat (2) @(negedge clk_in);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    repeat (4) @(negedge clk_in);
    send_refresh(1'b1);
    capture_frame("partial_cs", 0);
  endtask

  task automatic test_unknown_cmd();
    send_cmd(CMD_WR_DATA);
    send_data(8'hA1);
    send_data(8'hA2);
    send_cmd(8'h55);
    quiet_check("unknown_no_start", 100);
    send_data(8'hA3);
    send_refresh(1'b1);
    capture_frame("unknown_cmd", 0);
  endtask

  task automatic test_reset_mid_send();
    bit started = 1'b0;
    send_refresh(1'b0);
    for (int w = 0; w < 50 && !started; w++) begin
      @(negedge clk_in);
      if (ws2812_data_out !== 8'h00) started = 1'b1;
    end
    n_checks++;
    if (!started) begin
      n_fail++;
      $display("FAIL abort_start: got no frame start, required one");
    end
    // bit 3, position 1: every line is high here for either bit value
    repeat (37) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    n_checks++;
    if (ws2812_data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_out: got %h required 00", ws2812_data_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    mdl_ch = 0; mdl_idx = 0; mdl_full = 1'b0;
    quiet_check("abort_idle", 200);
    fill_buffers(8'h3C, 8'd5);
    send_refresh(1'b1);
    capture_frame("after_abort", 0);
  endtask

  initial begin
    rst_in   = 1'b1;
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    spi.dc   = 1'b0;
    test_reset();
    test_basic();
    test_wrap_channel();
    test_drop_after_full();
    test_back_to_back();
    test_partial_cs();
    test_unknown_cmd();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ws2812_led_controller.md
WS2812_LED_CONTROLLER -- requirements
Module: ws2812_led_controller

Interface
REQ-001 SHALL have parameter N_LED, default 64, LEDs per output channel.
REQ-002 SHALL have parameter T0H, default 80, high time of a 0 bit in clk_in cycles (0.4 us at 200 MHz).
REQ-003 SHALL have parameter T1H, default 160, high time of a 1 bit in clk_in cycles (0.8 us).
REQ-004 SHALL have parameter T_BIT, default 250, total bit period in clk_in cycles (1.25 us).
REQ-005 SHALL have parameter T_RST, default 10000, latch low time in clk_in cycles (50 us).
REQ-006 SHALL have port clk_in, input, 1 bit, system clock, 200 MHz nominal; one clock domain, all logic on its rising edge.
REQ-007 SHALL have port rst_in, input, 1 bit, reset; synchronous, active-high.
REQ-008 SHALL have port dc_in, input, 1 bit, 0 = command byte, 1 = data byte.
REQ-009 SHALL have port spi_sclk_in, input, 1 bit, SPI clock, mode 0, at most clk_in/4.
REQ-010 SHALL have port spi_mosi_in, input, 1 bit, SPI data, MSB first.
REQ-011 SHALL have port spi_cs_n_in, input, 1 bit, SPI chip select, active-low.
REQ-012 SHALL have port ws2812_data_out, output, 8 bits, one WS2812 serial line per channel.

Function
REQ-013 SHALL pass spi_sclk_in, spi_mosi_in, spi_cs_n_in and dc_in each through a 2-flop synchronizer into clk_in.
REQ-014 SHALL sample MOSI on each synchronized SCLK rising edge while CS is low, shifting MSB first.
REQ-015 SHALL complete a byte on the 8th sampled bit and latch synchronized dc_in at that same cycle.
REQ-016 SHALL clear the bit counter whenever CS is high; a partial byte is discarded.
REQ-017 SHALL decode command 0xDA (WR_DATA): reset the write pointer to channel 0, byte 0.
REQ-018 SHALL decode command 0x2C (REFRESH): start transmission if idle; ignore if busy.
REQ-019 SHALL ignore all other command values, with no state change.
REQ-020 SHALL store each data byte at {channel, index} and then increment index.
REQ-021 SHALL wrap index from 3*N_LED-1 to 0 and increment channel; after channel 7 wrap, further data bytes are dropped until the next 0xDA.
REQ-022 SHALL order bytes within an LED as G, R, B; each channel buffer holds 3*N_LED bytes.
REQ-023 SHALL accept buffer writes during transmission; mid-frame writes MAY tear, no double buffering.
REQ-024 SHALL run the transmitter with states IDLE -> SEND -> LATCH -> IDLE.
REQ-025 SHALL, in SEND, drive all 8 channels in parallel, byte index 0..3*N_LED-1, bits MSB first.
REQ-026 SHALL drive each bit high for T0H or T1H cycles (0 or 1 respectively), then low for the rest of T_BIT.
REQ-027 SHALL make the first rising edge on ws2812_data_out within 4 clk_in cycles after the REFRESH byte completes.
REQ-028 SHALL hold all outputs low for T_RST cycles in LATCH, then return to IDLE; a new REFRESH is accepted from IDLE only.
REQ-029 SHALL hold all outputs low in IDLE.
REQ-030 SHALL treat dc_in changing while CS is high as legal; dc_in is only sampled at byte completion.

Reset
REQ-031 SHALL, on rst_in high, clear the shift register, bit counter, write pointer and state (state = IDLE), and drive ws2812_data_out = 8'h00 on the next edge.
REQ-032 SHALL, on reset mid-transmission, abort the transmission immediately with outputs low.
REQ-033 SHALL leave buffer contents undefined after reset.

Structure
REQ-034 SHALL define command codes (CMD_WR_DATA = 8'hDA, CMD_REFRESH = 8'h2C) and the transmitter state enum in package ws2812_pkg.
REQ-035 SHALL implement one sub-module, ws2812_spi_slave (synchronizers, shift register; outputs byte_valid, byte_data, byte_is_data).
REQ-036 SHALL implement the buffers as 8 inferred RAMs of 3*N_LED x 8 bits.

Verification
REQ-037 SHALL cover: byte 0xDA with dc=0, then 3 data bytes 0xFF,0x00,0x81, then 0x2C -> channel 0 emits bits 11111111 00000000 10000001 (high 160/80 cycles, period 250); channels 1-7 emit LED0 = 0.
REQ-038 SHALL cover: 3*N_LED+1 data bytes after 0xDA -> last byte lands in channel 1, index 0.
REQ-039 SHALL cover: REFRESH sent while busy -> ignored; exactly one frame of 24*N_LED bits, then T_RST low.
REQ-040 SHALL cover: CS raised after 5 bits, then a full byte 0x2C -> only the full byte is decoded.
REQ-041 SHALL cover: unknown command 0x55 -> no pointer or state change.
REQ-042 SHALL cover: rst_in asserted mid-SEND -> outputs 8'h00 next cycle; state IDLE.
